// File: rtl/ppg_uart_tx_sched.sv
// Takes every DECIM-th LED1/LED2 sample pair and sends it as a 7-byte frame over a shared byte UART.
// The frame bytes are: SYNC, then LED1 high/mid/low, then LED2 high/mid/low, with 2-bit tags 00/01 on the high bytes.
module ppg_uart_tx_sched #(
  parameter int         DATA_W  = 22,
  parameter int         DECIM   = 13,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_new_samples,
  input  logic [DATA_W-1:0] in_led_one,
  input  logic [DATA_W-1:0] in_led_two,
  input  logic              in_tx_active,
  input  logic              in_tx_done,
  input  logic              in_clr_flags,
  output logic              out_tx_dv,
  output logic [7:0]        out_tx_byte,
  output logic              out_busy,
  output logic              out_overrun,
  output logic              out_timeout,
  output logic [7:0]        out_frame_cnt
);

  // state  | meaning
  // IDLE   | no frame; waiting for a decimation hit
  // LOAD   | present byte[byte_idx] to the UART and raise dv
  // REQ    | dv held until the UART reports active
  // WAIT   | waiting for the done rising edge of the current byte
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT} state_t;

  localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t         state_q, state_d;
  logic [DCW-1:0] decim_q, decim_d;
  logic [2:0]     idx_q, idx_d;
  logic [21:0]    led1_q, led1_d;
  logic [21:0]    led2_q, led2_d;
  logic           done_q;
  logic [TOW-1:0] tmr_q, tmr_d;
  logic           dv_q, dv_d;
  logic [7:0]     byte_q, byte_d;
  logic           busy_q, busy_d;
  logic           overrun_q, overrun_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     frame_cnt_q, frame_cnt_d;

  logic hit;
  logic done_rise;
  logic overrun_set;
  logic timeout_set;

  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [21:0] a,
                                            input logic [21:0] b);
    case (idx)
      3'd0:    frame_byte = SYNC;
      3'd1:    frame_byte = {2'b00, a[21:16]};
      3'd2:    frame_byte = a[15:8];
      3'd3:    frame_byte = a[7:0];
      3'd4:    frame_byte = {2'b01, b[21:16]};
      3'd5:    frame_byte = b[15:8];
      3'd6:    frame_byte = b[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    idx_d       = idx_q;
    led1_d      = led1_q;
    led2_d      = led2_q;
    tmr_d       = tmr_q;
    dv_d        = dv_q;
    byte_d      = byte_q;
    frame_cnt_d = frame_cnt_q;
    overrun_set = 1'b0;
    timeout_set = 1'b0;

    hit       = in_new_samples && (decim_q == DCW'(DECIM - 1));
    done_rise = in_tx_done && !done_q;

    // The decimator keeps counting while a frame is in flight, so hits stay evenly spaced.
    if (in_new_samples) begin
      decim_d = hit ? '0 : decim_q + DCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          led1_d  = 22'(in_led_one);
          led2_d  = 22'(in_led_two);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        byte_d  = frame_byte(idx_q, led1_q, led2_q);
        dv_d    = 1'b1;
        tmr_d   = TOW'(TIMEOUT - 1);
        state_d = S_REQ;
      end
      S_REQ: begin
        if (in_tx_active) begin
          dv_d    = 1'b0;
          tmr_d   = TOW'(TIMEOUT - 1);
          state_d = S_WAIT;
        end else if (tmr_q == '0) begin
          dv_d        = 1'b0;
          idx_d       = '0;
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr_q - TOW'(1);
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          if (idx_q == 3'd6) begin
            idx_d       = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD;
          end
        end else if (tmr_q == '0) begin
          idx_d       = '0;
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmr_d = tmr_q - TOW'(1);
        end
      end
      default: begin
        dv_d    = 1'b0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (hit && (state_q != S_IDLE)) begin
      overrun_set = 1'b1;
    end

    // A set event in the same cycle as a clear leaves the flag set.
    overrun_d = overrun_set || (overrun_q && !in_clr_flags);
    timeout_d = timeout_set || (timeout_q && !in_clr_flags);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      decim_q     <= '0;
      idx_q       <= '0;
      led1_q      <= '0;
      led2_q      <= '0;
      done_q      <= 1'b0;
      tmr_q       <= '0;
      dv_q        <= 1'b0;
      byte_q      <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      decim_q     <= decim_d;
      idx_q       <= idx_d;
      led1_q      <= led1_d;
      led2_q      <= led2_d;
      done_q      <= in_tx_done;
      tmr_q       <= tmr_d;
      dv_q        <= dv_d;
      byte_q      <= byte_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_tx_dv     = dv_q;
  assign out_tx_byte   = byte_q;
  assign out_busy      = busy_q;
  assign out_overrun   = overrun_q;
  assign out_timeout   = timeout_q;
  assign out_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ppg_uart_tx_sched.sv
// Random-stimulus bench for ppg_uart_tx_sched. A UART model drives the handshake.
// A frame-level model predicts the bytes, the frame count and the sticky flags.
`timescale 1ns/1ps
module tb_ppg_uart_tx_sched;
  localparam int DATA_W  = 22;
  localparam int DECIM   = 13;
  localparam int TIMEOUT = 100;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_new_samples = 1'b0;
  logic [DATA_W-1:0] in_led_one = '0;
  logic [DATA_W-1:0] in_led_two = '0;
  logic              in_tx_active = 1'b0;
  logic              in_tx_done = 1'b0;
  logic              in_clr_flags = 1'b0;
  logic              out_tx_dv;
  logic [7:0]        out_tx_byte;
  logic              out_busy;
  logic              out_overrun;
  logic              out_timeout;
  logic [7:0]        out_frame_cnt;

  always #5 clk = ~clk;

  ppg_uart_tx_sched #(.DATA_W(DATA_W), .DECIM(DECIM), .SYNC(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .in_new_samples(in_new_samples),
    .in_led_one(in_led_one), .in_led_two(in_led_two),
    .in_tx_active(in_tx_active), .in_tx_done(in_tx_done), .in_clr_flags(in_clr_flags),
    .out_tx_dv(out_tx_dv), .out_tx_byte(out_tx_byte), .out_busy(out_busy),
    .out_overrun(out_overrun), .out_timeout(out_timeout), .out_frame_cnt(out_frame_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // UART model: after seeing dv, raises active, serialises, then pulses done for done_hold clks.
  bit uart_en = 1'b1;
  bit uart_nodone = 1'b0;
  bit uart_busy = 1'b0;
  int done_hold = 1;
  int uart_slow = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && out_tx_dv && reset_n) begin
        uart_busy = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_tx_active = 1'b1;
        repeat ($urandom_range(2, 6) + uart_slow) @(negedge clk);
        in_tx_active = 1'b0;
        if (!uart_nodone) begin
          in_tx_done = 1'b1;
          repeat (done_hold) @(negedge clk);
          in_tx_done = 1'b0;
        end
        uart_busy = 1'b0;
      end
    end
  end

  // Every byte handed to the UART is one rising edge of dv.
  logic [7:0] got_q[$];
  logic dv_prev = 1'b0;
  always @(negedge clk) begin
    if (out_tx_dv && !dv_prev) got_q.push_back(out_tx_byte);
    dv_prev = out_tx_dv;
  end

  // Frame-level reference model state
  int pcount = 0;
  int exp_frames = 0;
  bit frame_open = 1'b0;
  bit exp_ovr = 1'b0;
  bit exp_tmo = 1'b0;
  logic [21:0] hit_l1 = '0;
  logic [21:0] hit_l2 = '0;

  function automatic logic [7:0] exp_byte(input logic [21:0] a, input logic [21:0] b, input int i);
    int ai = int'(a);
    int bi = int'(b);
    case (i)
      0: return 8'hA5;
      1: return 8'(ai / 65536);
      2: return 8'((ai / 256) % 256);
      3: return 8'(ai % 256);
      4: return 8'(64 + bi / 65536);
      5: return 8'((bi / 256) % 256);
      default: return 8'(bi % 256);
    endcase
  endfunction

  task automatic pulse(input logic [21:0] a, input logic [21:0] b, input bit clr);
    bit set_ovr;
    set_ovr = 1'b0;
    in_led_one = a;
    in_led_two = b;
    in_new_samples = 1'b1;
    in_clr_flags = clr;
    pcount++;
    if (pcount % DECIM == 0) begin
      if (frame_open) set_ovr = 1'b1;
      else begin
        frame_open = 1'b1;
        hit_l1 = a;
        hit_l2 = b;
      end
    end
    exp_ovr = set_ovr ? 1'b1 : (clr ? 1'b0 : exp_ovr);
    if (clr) exp_tmo = 1'b0;
    @(negedge clk);
    in_new_samples = 1'b0;
    in_clr_flags = 1'b0;
    in_led_one = 22'($urandom);
    in_led_two = 22'($urandom);
  endtask

  // Pulses random data until the next pulse is a hit, then sends (a, b) as that hit.
  task automatic to_hit(input logic [21:0] a, input logic [21:0] b, input bit clr, input int gap);
    while ((pcount + 1) % DECIM != 0) begin
      pulse(22'($urandom), 22'($urandom), 1'b0);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
    pulse(a, b, clr);
  endtask

  task automatic clear_flags();
    in_clr_flags = 1'b1;
    @(negedge clk);
    in_clr_flags = 1'b0;
    exp_ovr = 1'b0;
    exp_tmo = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_busy || uart_busy) && n < 4000) begin
      @(negedge clk);
      in_led_one = 22'($urandom);
      in_led_two = 22'($urandom);
      n++;
    end
    if (n >= 4000) check("idle_budget", 32'd1, 32'd0);
    @(negedge clk);
    frame_open = 1'b0;
  endtask

  task automatic wait_bytes(input int k);
    int n;
    n = 0;
    while (got_q.size() < k && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("bytes_budget", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_len"}, got_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < got_q.size())
        check($sformatf("%s_b%0d", tag, i), got_q[i], exp_byte(hit_l1, hit_l2, i));
    end
    got_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no summary expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [21:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_dv", out_tx_dv, 0);
    check("rst_busy", out_busy, 0);
    check("rst_ovr", out_overrun, 0);
    check("rst_tmo", out_timeout, 0);
    check("rst_cnt", out_frame_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // directed frame with a latency check on dv
    to_hit(22'h3ABCDE, 22'h012345, 1'b0, 2);
    check("lat_p0", out_tx_dv, 0);
    @(negedge clk);
    check("lat_p1", out_tx_dv, 1);
    wait_idle();
    exp_frames++;
    check_frame("dir");
    check("dir_cnt", out_frame_cnt, exp_frames);
    check("dir_busy", out_busy, 0);

    // random frames, done held 1..3 clks
    for (int f = 0; f < 6; f++) begin
      done_hold = $urandom_range(1, 3);
      a = 22'($urandom);
      b = 22'($urandom);
      to_hit(a, b, 1'b0, 3);
      wait_idle();
      exp_frames++;
      check_frame("rnd");
      check("rnd_cnt", out_frame_cnt, exp_frames % 256);
    end
    done_hold = 2;
    check("ovr_clean", out_overrun, exp_ovr);

    // overrun during byte 2, clear alone, then clear colliding with a new drop
    uart_slow = 20;
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    wait_bytes(3);
    to_hit(22'($urandom), 22'($urandom), 1'b0, 0);
    check("ovr_set", out_overrun, exp_ovr);
    clear_flags();
    check("ovr_clr", out_overrun, exp_ovr);
    to_hit(22'($urandom), 22'($urandom), 1'b1, 0);
    check("ovr_clr_same", out_overrun, exp_ovr);
    wait_idle();
    uart_slow = 0;
    exp_frames++;
    check_frame("ovr");
    check("ovr_cnt", out_frame_cnt, exp_frames);
    check("ovr_hold", out_overrun, exp_ovr);
    clear_flags();
    check("ovr_clr2", out_overrun, exp_ovr);

    // UART never goes active: dv must last exactly TIMEOUT clks
    uart_en = 1'b0;
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_tx_dv) cnt++;
      else if (cnt > 0) break;
    end
    exp_tmo = 1'b1;
    frame_open = 1'b0;
    check("tmo_req_len", cnt, TIMEOUT);
    check("tmo_req_flag", out_timeout, exp_tmo);
    check("tmo_req_busy", out_busy, 0);
    check("tmo_req_cnt", out_frame_cnt, exp_frames);
    check("tmo_req_nbytes", got_q.size(), 1);
    got_q.delete();
    uart_en = 1'b1;
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    wait_idle();
    exp_frames++;
    check_frame("tmo_fresh");
    check("tmo_fresh_cnt", out_frame_cnt, exp_frames);

    // UART goes active but never reports done
    clear_flags();
    check("tmo_clr", out_timeout, exp_tmo);
    uart_nodone = 1'b1;
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    wait_idle();
    exp_tmo = 1'b1;
    check("tmo_wait_flag", out_timeout, exp_tmo);
    check("tmo_wait_cnt", out_frame_cnt, exp_frames);
    check("tmo_wait_nbytes", got_q.size(), 1);
    got_q.delete();
    uart_nodone = 1'b0;

    // reset during byte 4, with the timeout flag still set
    exp_ovr = 1'b1;
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    to_hit(22'($urandom), 22'($urandom), 1'b0, 0);
    wait_bytes(5);
    reset_n = 1'b0;
    @(negedge clk);
    check("mrst_dv", out_tx_dv, 0);
    check("mrst_busy", out_busy, 0);
    check("mrst_cnt", out_frame_cnt, 0);
    check("mrst_ovr", out_overrun, 0);
    check("mrst_tmo", out_timeout, 0);
    reset_n = 1'b1;
    pcount = 0;
    exp_frames = 0;
    exp_ovr = 1'b0;
    exp_tmo = 1'b0;
    frame_open = 1'b0;
    wait_idle();
    got_q.delete();
    to_hit(22'($urandom), 22'($urandom), 1'b0, 2);
    wait_idle();
    exp_frames++;
    check_frame("post_rst");
    check("post_rst_cnt", out_frame_cnt, exp_frames);
    check("post_rst_ovr", out_overrun, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
